reg_frame_rx: RTL and testbench
===============================

// Module: reg_frame_rx
// PURPOSE
//  Upstream frame assembler for the register-access path. Collects a 4-byte frame (CMD, ADDR, WDATA, CRC) from
//  the serial-interface byte stream, runs CRC8 (poly 1+x+x^2+x^3+x^5+x^8, init 0xFF) over the 3 payload bytes,
//  checks the 4th byte against it, and presents a validated request to the register file with a valid/ready handshake.
//  Bad-CRC, aborted and timed-out frames are dropped, flagged and counted.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles between accepted bytes inside a frame before abort (1..2^TO_W-1)
//  TO_W         8    width of inter-byte timeout counter
// PORTS
//  clk          in   1  clock
//  rst          in   1  synchronous active-high reset
//  in_vld       in   1  byte valid from serial interface
//  in_data      in   8  byte data
//  in_rdy       out  1  byte accepted when in_vld & in_rdy
//  frame_abort  in   1  chip-select deassert; discards any partial frame
//  req_vld      out  1  validated request pending
//  req_rdy      in   1  register file takes request when req_vld & req_rdy
//  req_cmd      out  8  frame byte 0
//  req_addr     out  8  frame byte 1
//  req_wdata    out  8  frame byte 2
//  crc_err      out  1  1-cycle pulse: CRC byte mismatch
//  to_err       out  1  1-cycle pulse: inter-byte timeout
//  err_cnt      out  8  saturating count of crc_err + to_err events
// BEHAVIOUR
//  Reset: state=IDLE, byte index=0, crc=0xFF, in_rdy=0 for the reset cycle then 1, req_vld=0, req_*=0x00,
//   crc_err=to_err=0, err_cnt=0, timeout counter=0. Reset mid-frame or mid-HOLD discards everything.
//  Per-byte CRC update: x=crc^byte; next[0]=x0^x3^x5^x7; [1]=x0^x1^x3^x4^x5^x6^x7; [2]=x0^x1^x2^x3^x4^x6;
//   [3]=x0^x1^x2^x4; [4]=x1^x2^x3^x5; [5]=x0^x2^x4^x5^x6^x7; [6]=x1^x3^x5^x6^x7; [7]=x2^x4^x6^x7. No final XOR.
//  States: IDLE -> COLLECT on first accepted byte (CMD); COLLECT counts bytes 1..3; on accepting byte 3 (CRC):
//   match -> HOLD, mismatch -> IDLE with crc_err pulse. HOLD -> IDLE on req_vld&req_rdy.
//  in_rdy=1 in IDLE/COLLECT, 0 in HOLD. Bytes offered in HOLD stall (not dropped).
//  Latency: req_vld rises the cycle after the CRC byte is accepted; req_* stable while req_vld=1.
//   Back-to-back: after handshake, in_rdy=1 next cycle; new CMD accepted in that cycle.
//  Timeout: counter clears on each accepted byte, increments in COLLECT only; reaching TIMEOUT_CYC -> IDLE, to_err
//   pulse next cycle, crc=0xFF, index=0. Not active in IDLE or HOLD.
//  frame_abort: in COLLECT -> IDLE, no error pulse, no count; a byte accepted the same cycle is discarded.
//   In HOLD ignored (validated request still delivered). In IDLE: blocks acceptance that cycle (in_rdy=0).
//  crc reset to 0xFF on every return to IDLE. err_cnt saturates at 0xFF; crc_err and to_err never coincide.
// TESTING
//  T1 frame 00,00,00,69, req_rdy=1 -> req_vld 1 cycle after byte 4, cmd/addr/wdata=00, no errors.
//  T2 frame 00,00,00,68 -> crc_err 1 cycle, err_cnt=1, req_vld stays 0, next frame 00,00,00,69 accepted OK.
//  T3 valid frame with req_rdy=0 for 10 cycles -> req_vld held, in_rdy=0, offered byte stalls; released on req_rdy.
//  T4 bytes 00,00 then idle TIMEOUT_CYC cycles -> to_err pulse, err_cnt+1; following 00,00,00,69 passes.
//  T5 frame_abort after 2 bytes -> no pulse, err_cnt unchanged; next full frame 00,00,00,69 passes.
//  T6 257 bad-CRC frames -> err_cnt saturates at 0xFF; rst mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/reg_frame_rx.sv
// reg_frame_rx
//   Assembles a 4-byte register-access frame (CMD, ADDR, WDATA, CRC) from a
//   byte stream. A CRC8 (poly 0x2F, init 0xFF, no final XOR) is run over the
//   three payload bytes and compared with the fourth byte. Good frames are held
//   as a request for the register file until it is taken. Bad-CRC and
//   timed-out frames are dropped, flagged with a one-cycle pulse and counted.
//   Aborted frames are dropped silently.
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   in_vld/in_data/in_rdy   : byte stream in (taken when in_vld & in_rdy)
//   frame_abort             : chip-select deassert, discards a partial frame
//   req_vld/req_rdy         : validated request handshake
//   req_cmd/addr/wdata      : payload bytes of the validated frame
//   crc_err, to_err         : one-cycle error pulses
//   err_cnt                 : saturating count of error pulses
module reg_frame_rx #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld,
  input  logic [7:0] in_data,
  output logic       in_rdy,
  input  logic       frame_abort,
  output logic       req_vld,
  input  logic       req_rdy,
  output logic [7:0] req_cmd,
  output logic [7:0] req_addr,
  output logic [7:0] req_wdata,
  output logic       crc_err,
  output logic       to_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  // Timeout fires when the counter has already spent TIMEOUT_CYC-1 idle
  // cycles and another idle cycle passes.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state_q;
  logic [1:0]      idx_q;
  logic [7:0]      crc_q;
  logic [7:0]      crc_d;
  logic [TO_W-1:0] to_q;
  logic            rdy_q;
  logic [7:0]      cmd_q, addr_q, wdata_q;
  logic            crc_err_q, to_err_q;
  logic [7:0]      err_cnt_q;
  logic            accept;
  logic            crc_bad;
  logic            crc_good;
  logic            timeout_hit;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] n;
    x    = c ^ b;
    n[0] = x[0] ^ x[3] ^ x[5] ^ x[7];
    n[1] = x[0] ^ x[1] ^ x[3] ^ x[4] ^ x[5] ^ x[6] ^ x[7];
    n[2] = x[0] ^ x[1] ^ x[2] ^ x[3] ^ x[4] ^ x[6];
    n[3] = x[0] ^ x[1] ^ x[2] ^ x[4];
    n[4] = x[1] ^ x[2] ^ x[3] ^ x[5];
    n[5] = x[0] ^ x[2] ^ x[4] ^ x[5] ^ x[6] ^ x[7];
    n[6] = x[1] ^ x[3] ^ x[5] ^ x[6] ^ x[7];
    n[7] = x[2] ^ x[4] ^ x[6] ^ x[7];
    return n;
  endfunction

  assign crc_d = crc8_step(crc_q, in_data);

  // An abort in IDLE must block the byte in the same cycle, so the
  // registered ready is gated combinationally here.
  assign in_rdy = rdy_q & ~((state_q == IDLE) & frame_abort);
  assign accept = in_vld & in_rdy;

  // Abort takes priority over both CRC check and timeout in COLLECT.
  assign crc_good    = (state_q == COLLECT) & ~frame_abort & accept &
                       (idx_q == 2'd3) & (in_data == crc_q);
  assign crc_bad     = (state_q == COLLECT) & ~frame_abort & accept &
                       (idx_q == 2'd3) & (in_data != crc_q);
  assign timeout_hit = (state_q == COLLECT) & ~frame_abort & ~accept &
                       (to_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      crc_q     <= 8'hFF;
      to_q      <= '0;
      rdy_q     <= 1'b0;
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      crc_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      crc_err_q <= crc_bad;
      to_err_q  <= timeout_hit;
      if ((crc_bad || timeout_hit) && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end

      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            cmd_q   <= in_data;
            crc_q   <= crc_d;
            idx_q   <= 2'd1;
            to_q    <= '0;
            state_q <= COLLECT;
          end
        end

        COLLECT: begin
          if (frame_abort || crc_bad || timeout_hit) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            crc_q   <= 8'hFF;
            to_q    <= '0;
          end else if (crc_good) begin
            state_q <= HOLD;
            rdy_q   <= 1'b0;
            idx_q   <= 2'd0;
            crc_q   <= 8'hFF;
            to_q    <= '0;
          end else if (accept) begin
            to_q  <= '0;
            crc_q <= crc_d;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd1) begin
              addr_q <= in_data;
            end else begin
              wdata_q <= in_data;
            end
          end else begin
            to_q <= to_q + 1'b1;
          end
        end

        HOLD: begin
          if (req_rdy) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_vld   = (state_q == HOLD);
  assign req_cmd   = cmd_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;
  assign crc_err   = crc_err_q;
  assign to_err    = to_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_reg_frame_rx.sv
module tb_reg_frame_rx;

  localparam int TIMEOUT = 255;
  localparam logic [1:0] EV_CRC = 2'd1;
  localparam logic [1:0] EV_TO  = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld;
  logic [7:0] in_data;
  logic       in_rdy;
  logic       frame_abort;
  logic       req_vld;
  logic       req_rdy;
  logic [7:0] req_cmd, req_addr, req_wdata;
  logic       crc_err, to_err;
  logic [7:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int exp_err = 0;

  logic [23:0] req_q[$];
  logic [1:0]  ev_q[$];

  reg_frame_rx #(.TIMEOUT_CYC(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .frame_abort(frame_abort), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .crc_err(crc_err), .to_err(to_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  // Independent bitwise MSB-first CRC8, poly 0x2F, init 0xFF.
  function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] a, input logic [7:0] w);
    logic [7:0] r;
    logic [7:0] bytes [3];
    bytes[0] = c; bytes[1] = a; bytes[2] = w;
    r = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      r = r ^ bytes[i];
      for (int j = 0; j < 8; j++) begin
        r = r[7] ? ((r << 1) ^ 8'h2F) : (r << 1);
      end
    end
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_vld  = 1'b1;
    in_data = b;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_rdy) break;
      n++;
      if (n > 500) begin
        check("byte_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] w,
                            input logic [7:0] k, input bit ok);
    if (ok) req_q.push_back({c, a, w});
    else begin
      ev_q.push_back(EV_CRC);
      exp_err++;
    end
    send_byte(c);
    send_byte(a);
    send_byte(w);
    send_byte(k);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents something.
  logic       prev_vld = 1'b0;
  logic       prev_hs  = 1'b0;
  logic [23:0] prev_req = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_vld <= 1'b0;
      prev_hs  <= 1'b0;
    end else begin
      if (req_vld && prev_vld && !prev_hs)
        check("req_stable", {8'h0, req_cmd, req_addr, req_wdata}, {8'h0, prev_req});
      if (req_vld) check("in_rdy_in_hold", in_rdy, 0);
      if (req_vld && req_rdy) begin
        if (req_q.size() == 0) check("req_unexpected", {8'h0, req_cmd, req_addr, req_wdata}, 32'hFFFFFFFF);
        else check("req_data", {8'h0, req_cmd, req_addr, req_wdata}, {8'h0, req_q.pop_front()});
      end
      if (crc_err || to_err) begin
        check("err_no_coincide", {crc_err, to_err} == 2'b11, 0);
        if (ev_q.size() == 0) check("err_unexpected", {crc_err, to_err}, 0);
        else check("err_event", crc_err ? EV_CRC : EV_TO, ev_q.pop_front());
      end
      prev_vld <= req_vld;
      prev_hs  <= req_vld & req_rdy;
      prev_req <= {req_cmd, req_addr, req_wdata};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] k;
    rst = 1'b1; in_vld = 1'b0; in_data = 8'h00; frame_abort = 1'b0; req_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_req_vld", req_vld, 0);
    check("rst_req", {8'h0, req_cmd, req_addr, req_wdata}, 0);
    check("rst_errs", {crc_err, to_err, err_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    check("in_rdy_after_rst", in_rdy, 1);

    // T1: good frame, latency one cycle after CRC byte
    send_frame(8'h00, 8'h00, 8'h00, 8'h69, 1'b1);
    @(negedge clk);
    check("t1_req_vld_latency", req_vld, 1);
    idle(2);
    check("t1_err_cnt", err_cnt, 0);

    // Model-generated vector, back-to-back frames
    k = crc_model(8'hA5, 8'h3C, 8'hF0);
    send_frame(8'hA5, 8'h3C, 8'hF0, k, 1'b1);
    k = crc_model(8'h01, 8'h80, 8'hFF);
    send_frame(8'h01, 8'h80, 8'hFF, k, 1'b1);
    idle(2);

    // T2: bad CRC then recovery
    send_frame(8'h00, 8'h00, 8'h00, 8'h68, 1'b0);
    @(negedge clk);
    check("t2_no_req", req_vld, 0);
    idle(2);
    check("t2_err_cnt", err_cnt, 1);
    send_frame(8'h00, 8'h00, 8'h00, 8'h69, 1'b1);
    idle(2);

    // T3: request held, offered byte stalls
    req_rdy = 1'b0;
    k = crc_model(8'h12, 8'h34, 8'h56);
    send_frame(8'h12, 8'h34, 8'h56, k, 1'b1);
    req_q.push_back(24'h000000);
    in_vld = 1'b1; in_data = 8'h00;
    repeat (10) begin
      @(negedge clk);
      check("t3_hold_vld", req_vld, 1);
      check("t3_hold_cmd", {req_cmd, req_addr, req_wdata}, 24'h123456);
    end
    @(posedge clk); #1;
    req_rdy = 1'b1;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h69);
    idle(2);

    // T4: timeout after two bytes, then recovery
    ev_q.push_back(EV_TO);
    exp_err++;
    send_byte(8'h00);
    send_byte(8'h00);
    idle(TIMEOUT + 5);
    check("t4_err_cnt", err_cnt, exp_err);
    check("t4_to_seen", ev_q.size(), 0);
    send_frame(8'h00, 8'h00, 8'h00, 8'h69, 1'b1);
    // long but sub-timeout gap inside a frame must not abort
    req_q.push_back(24'h000000);
    send_byte(8'h00);
    idle(200);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h69);
    idle(2);
    check("t4_gap_err_cnt", err_cnt, exp_err);

    // T5: abort after two bytes, with a byte accepted in the abort cycle
    send_byte(8'h00);
    send_byte(8'h00);
    in_vld = 1'b1; in_data = 8'h00; frame_abort = 1'b1;
    @(negedge clk);
    check("t5_rdy_collect_abort", in_rdy, 1);
    @(posedge clk); #1;
    in_vld = 1'b0; frame_abort = 1'b0;
    idle(3);
    check("t5_err_cnt", err_cnt, exp_err);
    send_frame(8'h00, 8'h00, 8'h00, 8'h69, 1'b1);
    idle(2);
    // abort in IDLE blocks acceptance
    frame_abort = 1'b1; in_vld = 1'b1; in_data = 8'h77;
    @(negedge clk);
    check("t5_idle_abort_rdy", in_rdy, 0);
    @(posedge clk); #1;
    frame_abort = 1'b0; in_vld = 1'b0;
    // abort in HOLD is ignored
    req_rdy = 1'b0;
    send_frame(8'h00, 8'h00, 8'h00, 8'h69, 1'b1);
    frame_abort = 1'b1;
    idle(1);
    frame_abort = 1'b0;
    idle(1);
    req_rdy = 1'b1;
    idle(3);
    check("t5_hold_abort_delivered", req_q.size(), 0);

    // T6: 257 bad frames saturate the error counter
    for (int i = 0; i < 257; i++) begin
      k = crc_model(8'(i), 8'h5A, 8'hC3) ^ 8'h01;
      send_frame(8'(i), 8'h5A, 8'hC3, k, 1'b0);
    end
    idle(3);
    check("t6_err_sat", err_cnt, 8'hFF);
    check("t6_ev_drained", ev_q.size(), 0);
    send_byte(8'hA5);
    send_byte(8'h5A);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_in_rdy", in_rdy, 0);
    check("t6_rst_req", {7'h0, req_vld, req_cmd, req_addr, req_wdata}, 0);
    check("t6_rst_errs", {crc_err, to_err, err_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    send_frame(8'h00, 8'h00, 8'h00, 8'h69, 1'b1);
    idle(3);

    check("end_req_q_empty", req_q.size(), 0);
    check("end_ev_q_empty", ev_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
